usb_fifo_snd: RTL and testbench
===============================

# usb_fifo_snd

Synchronous transmit FIFO for USB data-packet payload, the send-side counterpart of the receive FIFO. The endpoint/application side writes wide words; the packet serializer reads narrow words (one bit by default). The FIFO keeps an unreleased-packet mark so a packet can be replayed on retry, and it generates the USB CRC16 over the bits read.

## Interface
Parameters:
- ADDR_WIDTH, 4: log2 of storage size in bits.
- WDATA_WIDTH, 3: log2 of write width in bits (byte writes).
- RDATA_WIDTH, 0: log2 of read width in bits. Constraint: RDATA_WIDTH <= WDATA_WIDTH < ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst0_sync  input  1  reset. Synchronous, active-low.
- wr_en  input  1  write request; accepted when !fifo_full.
- wr_data  input  1<<WDATA_WIDTH  write word.
- rd_en  input  1  read request; accepted when !fifo_empty, !pkt_commit and !pkt_rewind.
- rd_data  output  1<<RDATA_WIDTH  word at the read pointer (combinational).
- fifo_full  output  1  fewer than 1<<WDATA_WIDTH free bits relative to the mark.
- fifo_empty  output  1  read pointer equals write pointer.
- pkt_commit  input  1  packet acknowledged: mark <= rd_addr, CRC re-initialised.
- pkt_rewind  input  1  retry: rd_addr <= mark, CRC re-initialised.
- fifo_level  output  ADDR_WIDTH+1  bits held between the mark and the write pointer.
- crc16  output  16  USB CRC16 of the bits read since the last commit, rewind or reset. Bit 0 is transmitted first.

## Operation
- Pointers wr_addr, rd_addr and mark are bit-granular, ADDR_WIDTH+1 bits wide; the MSB is the wrap bit. wr_addr advances by 1<<WDATA_WIDTH and rd_addr by 1<<RDATA_WIDTH, both modulo 2^(ADDR_WIDTH+1).
- Write: on an accepted write, mem[wr_addr +: W] <= wr_data. wr_data bit 0 goes to the lowest address, so it is read out first (LSB-first serialization).
- fifo_empty = (rd_addr == wr_addr).
- fifo_level = wr_addr − mark.
- fifo_full = (fifo_level > FIFO_LENGTH − W). Fullness counts against the mark, not rd_addr, so bits already read but not yet committed are never overwritten.
- CRC: polynomial x^16+x^15+x^2+1, reflected form 0xA001, init 0xFFFF, shift LSB-first.
  - On each accepted read, all 1<<RDATA_WIDTH bits of rd_data are processed in one cycle, bit 0 first.
  - crc16 = ~crc_reg, in reflected order.
- Priority per cycle: rst0_sync low > pkt_rewind > pkt_commit > rd_en.
  - When commit or rewind is asserted, a concurrent rd_en is ignored and the CRC goes to init.
  - If commit and rewind are asserted together, rewind wins.
  - Writes are independent of commit, rewind and read, except for the full gate.
- Wrap-around: pointer arithmetic is plain modulo; no special casing.
- Overflow or underflow attempts are silently dropped; pointers are unchanged.
- Reset values: all pointers 0, mem all 0, crc_reg 0xFFFF. Outputs after reset:
  - fifo_empty=1, fifo_full=0, fifo_level=0.
  - crc16=0x0000, rd_data=0.

## Timing
- All state updates on posedge clk. Reset takes effect at the first edge with rst0_sync low, including mid-packet.
- Write to read: fifo_empty falls and fifo_level/fifo_full update in the cycle after the write edge.
- rd_data is combinational from rd_addr. The serializer samples rd_data in the same cycle it asserts rd_en.
- crc16 reflects a read one cycle after its edge. After the last payload read, crc16 is valid on the next cycle and stays stable until the next accepted read, commit, rewind or reset.
- Commit frees space: fifo_full/fifo_level update the cycle after the commit edge.
- Rewind: rd_data shows the first bit after the mark the cycle after the rewind edge.

## Structure
- Shared package usb_pkg holds:
  - USB_CRC16_POLY_REFL = 16'hA001
  - USB_CRC16_INIT = 16'hFFFF
  - USB_CRC16_RESIDUAL = 16'hB001 (for receive-side checking)
- Sub-module usb_crc16: parameter N bits per step, inputs en/clr/data[N-1:0], output crc[15:0]. It is instantiated with N = 1<<RDATA_WIDTH and is reusable by the receive path.

## Test plan
- Reset, then idle: fifo_empty=1, fifo_full=0, fifo_level=0, crc16=0x0000; a pkt_commit with no data leaves crc16=0x0000 (zero-length packet CRC).
- ADDR_WIDTH=7: write ASCII "123456789" (0x31..0x39), then read 72 bits.
  - The bits arrive LSB-first per byte.
  - fifo_empty=1 after bit 72, and crc16=0xB4C8.
- ADDR_WIDTH=4, WDATA_WIDTH=3: write 0xA5 and 0x3C, and observe fifo_full=1.
  - A third write is dropped.
  - Reading all 16 bits leaves fifo_full=1 until pkt_commit.
  - After the commit, fifo_level=0 and a write is accepted.
- Write 0x12 0x34, read 16 bits, then pkt_rewind.
  - The re-read produces identical bits.
  - crc16 equals the value from the first pass.
- rd_en together with pkt_rewind, and rd_en together with pkt_commit: the read is not accepted and rd_addr takes the rewind/commit value. rst0_sync low mid-packet returns all reset values at the next edge.
- Wrap-around: 20 cycles of write byte / read 8 bits / commit, with payload 0x00..0x13; the read data matches and the level never exceeds 8.

Source files
------------

// File: rtl/usb_pkg.sv
// USB constants shared by the send and receive paths, plus the one-bit CRC16 update.
package usb_pkg;

    localparam logic [15:0] USB_CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] USB_CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] USB_CRC16_RESIDUAL  = 16'hB001;

    // One LSB-first step of the reflected CRC16 register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
        logic [15:0] w_shift;
        w_shift = {1'b0, crc[15:1]};
        if (crc[0] ^ d) w_shift = w_shift ^ USB_CRC16_POLY_REFL;
        return w_shift;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// USB CRC16 register consuming N bits per enabled cycle, bit 0 first.
// The output is the raw register, so a receiver can compare it against USB_CRC16_RESIDUAL.
module usb_crc16 #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst0_sync,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] data,
    output logic [15:0]  crc
);
    import usb_pkg::*;

    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    // NOTE: w_crc_next is given a default before the loop, so no latch is inferred.
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 0; i < N; i++) begin
            w_crc_next = crc16_step(w_crc_next, data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst0_sync) begin
            r_crc <= USB_CRC16_INIT;
        end else if (clr) begin
            r_crc <= USB_CRC16_INIT;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_fifo_snd.sv
// USB transmit FIFO: wide writes, narrow reads, a replay mark for retries,
// and a CRC16 over the bits read since the last commit or rewind.
module usb_fifo_snd #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WDATA_WIDTH = 3,
    parameter int RDATA_WIDTH = 0
) (
    input  logic                        clk,
    input  logic                        rst0_sync,
    input  logic                        wr_en,
    input  logic [(1<<WDATA_WIDTH)-1:0] wr_data,
    input  logic                        rd_en,
    output logic [(1<<RDATA_WIDTH)-1:0] rd_data,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    input  logic                        pkt_commit,
    input  logic                        pkt_rewind,
    output logic [ADDR_WIDTH:0]         fifo_level,
    output logic [15:0]                 crc16
);
    import usb_pkg::*;

    localparam int FIFO_LENGTH = 1 << ADDR_WIDTH;
    localparam int W           = 1 << WDATA_WIDTH;
    localparam int R           = 1 << RDATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] W_STEP     = (ADDR_WIDTH+1)'(W);
    localparam logic [ADDR_WIDTH:0] R_STEP     = (ADDR_WIDTH+1)'(R);
    localparam logic [ADDR_WIDTH:0] FULL_LIMIT = (ADDR_WIDTH+1)'(FIFO_LENGTH - W);

    logic [FIFO_LENGTH-1:0] r_mem;
    logic [ADDR_WIDTH:0]    r_wr_addr;
    logic [ADDR_WIDTH:0]    r_rd_addr;
    logic [ADDR_WIDTH:0]    r_mark;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic                   w_crc_clr;
    logic [15:0]            w_crc_reg;

    // Fullness is measured from the mark so uncommitted bits stay replayable.
    assign fifo_level = r_wr_addr - r_mark;
    assign fifo_full  = fifo_level > FULL_LIMIT;
    assign fifo_empty = r_rd_addr == r_wr_addr;
    assign rd_data    = r_mem[r_rd_addr[ADDR_WIDTH-1:0] +: R];

    assign w_wr_ok   = wr_en && !fifo_full;
    assign w_crc_clr = pkt_commit || pkt_rewind;
    assign w_rd_ok   = rd_en && !fifo_empty && !w_crc_clr;

    // NOTE: the storage is small and flop-based, so it is cleared by reset to give a defined rd_data.
    always_ff @(posedge clk) begin
        if (!rst0_sync) begin
            r_mem     <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_mark    <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr_addr[ADDR_WIDTH-1:0] +: W] <= wr_data;
                r_wr_addr <= r_wr_addr + W_STEP;
            end
            if (pkt_rewind) begin
                r_rd_addr <= r_mark;
            end else if (pkt_commit) begin
                r_mark <= r_rd_addr;
            end else if (w_rd_ok) begin
                r_rd_addr <= r_rd_addr + R_STEP;
            end
        end
    end

    usb_crc16 #(
        .N(R)
    ) u_crc16 (
        .clk       (clk),
        .rst0_sync (rst0_sync),
        .en        (w_rd_ok),
        .clr       (w_crc_clr),
        .data      (rd_data),
        .crc       (w_crc_reg)
    );

    assign crc16 = ~w_crc_reg;

endmodule

// File: tb/tb_usb_fifo_snd.sv
// Bench for usb_fifo_snd: directed stimulus pushes expected read bits into a
// scoreboard queue; a monitor pops and compares each accepted read.
module tb_usb_fifo_snd;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst0_sync = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          rd_en = 1'b0;
    logic          rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pkt_commit = 1'b0;
    logic          pkt_rewind = 1'b0;
    logic [AW:0]   fifo_level;
    logic [15:0]   crc16;

    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_q[$];

    usb_fifo_snd #(
        .ADDR_WIDTH  (AW),
        .WDATA_WIDTH (3),
        .RDATA_WIDTH (0)
    ) dut (
        .clk        (clk),
        .rst0_sync  (rst0_sync),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .pkt_commit (pkt_commit),
        .pkt_rewind (pkt_rewind),
        .fifo_level (fifo_level),
        .crc16      (crc16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic read_bits(input logic [7:0] b, input int nbits, input int first);
        for (int i = 0; i < nbits; i++) begin
            rd_en = 1'b1;
            exp_q.push_back(b[first+i]);
            step();
        end
        rd_en = 1'b0;
    endtask

    task automatic commit();
        pkt_commit = 1'b1;
        step();
        pkt_commit = 1'b0;
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Monitor: every read the DUT accepts must match the next queued bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst0_sync && rd_en && !pkt_commit && !pkt_rewind && !fifo_empty) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_read: got rd_data %0b with no expected bit at %0t",
                             rd_data, $time);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;

        // Reset and idle
        rst0_sync = 1'b0;
        step();
        step();
        rst0_sync = 1'b1;
        check("reset_empty",   32'(fifo_empty), 32'd1);
        check("reset_full",    32'(fifo_full),  32'd0);
        check("reset_level",   32'(fifo_level), 32'd0);
        check("reset_crc",     32'(crc16),      32'h0);
        check("reset_rd_data", 32'(rd_data),    32'd0);

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("underflow_level", 32'(fifo_level), 32'd0);
        check("underflow_empty", 32'(fifo_empty), 32'd1);
        check("underflow_crc",   32'(crc16),      32'h0);

        commit();
        check("zlp_crc", 32'(crc16), 32'h0);

        // CRC check string "123456789"
        for (int i = 0; i < 9; i++) write_byte(8'(8'h31 + i));
        check("crc_level", 32'(fifo_level), 32'd72);
        check("crc_empty", 32'(fifo_empty), 32'd0);
        for (int i = 0; i < 9; i++) read_bits(8'(8'h31 + i), 8, 0);
        check("crc_done_empty", 32'(fifo_empty), 32'd1);
        check("crc_check",      32'(crc16),      32'hB4C8);
        commit();
        check("crc_commit_level", 32'(fifo_level), 32'd0);
        check("crc_commit_crc",   32'(crc16),      32'h0);

        // Fill to full, drop an overflow write, drain, then free by commit
        for (int i = 0; i < 16; i++) begin
            write_byte(i[0] ? 8'h3C : 8'hA5);
            if (i == 14) check("full_at_120", 32'(fifo_full), 32'd0);
        end
        check("full_set",   32'(fifo_full),  32'd1);
        check("full_level", 32'(fifo_level), 32'd128);
        write_byte(8'hFF);
        check("overflow_level", 32'(fifo_level), 32'd128);
        for (int i = 0; i < 16; i++) read_bits(i[0] ? 8'h3C : 8'hA5, 8, 0);
        check("full_after_read",  32'(fifo_full),  32'd1);
        check("full_read_empty",  32'(fifo_empty), 32'd1);
        commit();
        check("full_commit_full",  32'(fifo_full),  32'd0);
        check("full_commit_level", 32'(fifo_level), 32'd0);
        write_byte(8'h5A);
        check("post_commit_level", 32'(fifo_level), 32'd8);
        read_bits(8'h5A, 8, 0);
        commit();

        // Rewind replays identical bits and CRC; rd_en during rewind is ignored
        m = ~crc_upd(crc_upd(16'hFFFF, 8'h12), 8'h34);
        write_byte(8'h12);
        write_byte(8'h34);
        read_bits(8'h12, 8, 0);
        read_bits(8'h34, 8, 0);
        check("pass1_crc", 32'(crc16), 32'(m));
        rd_en = 1'b1;
        pkt_rewind = 1'b1;
        step();
        rd_en = 1'b0;
        pkt_rewind = 1'b0;
        check("rewind_level", 32'(fifo_level), 32'd16);
        check("rewind_empty", 32'(fifo_empty), 32'd0);
        check("rewind_crc",   32'(crc16),      32'h0);
        read_bits(8'h12, 8, 0);
        read_bits(8'h34, 8, 0);
        check("pass2_crc", 32'(crc16), 32'(m));
        commit();

        // rd_en during commit is ignored; mark takes the pre-commit rd_addr
        write_byte(8'h10);
        read_bits(8'h10, 4, 0);
        rd_en = 1'b1;
        pkt_commit = 1'b1;
        step();
        rd_en = 1'b0;
        pkt_commit = 1'b0;
        check("cmt_rd_level", 32'(fifo_level), 32'd4);
        check("cmt_rd_data",  32'(rd_data),    32'd1);
        check("cmt_rd_crc",   32'(crc16),      32'h0);
        read_bits(8'h10, 4, 4);
        check("cmt_rd_empty", 32'(fifo_empty), 32'd1);
        commit();

        // Commit and rewind together: rewind wins
        write_byte(8'h95);
        read_bits(8'h95, 3, 0);
        pkt_commit = 1'b1;
        pkt_rewind = 1'b1;
        step();
        pkt_commit = 1'b0;
        pkt_rewind = 1'b0;
        check("both_level",   32'(fifo_level), 32'd8);
        check("both_rd_data", 32'(rd_data),    32'd1);
        read_bits(8'h95, 8, 0);
        commit();

        // Reset mid-packet; the byte at address 0 is 0xEF, so rd_data=0 needs cleared storage
        write_byte(8'hAB);
        write_byte(8'hCD);
        write_byte(8'hEF);
        read_bits(8'hAB, 5, 0);
        rst0_sync = 1'b0;
        step();
        rst0_sync = 1'b1;
        check("rst_empty",   32'(fifo_empty), 32'd1);
        check("rst_full",    32'(fifo_full),  32'd0);
        check("rst_level",   32'(fifo_level), 32'd0);
        check("rst_crc",     32'(crc16),      32'h0);
        check("rst_rd_data", 32'(rd_data),    32'd0);

        // Wrap-around: 20 packets of one byte each cross the 128-bit boundary
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i));
            check("wrap_level", 32'(fifo_level), 32'd8);
            read_bits(8'(i), 8, 0);
            commit();
        end
        check("wrap_end_empty", 32'(fifo_empty), 32'd1);

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
